// File: rtl/regfile_pkg.sv
// regfile_pkg: default sizes, FU tag constants and width helper for the multi-FU register file
package regfile_pkg;
    localparam int DEF_XLEN  = 32;
    localparam int DEF_NREGS = 32;
    localparam int DEF_NFU   = 5;
    localparam int FU_ALU  = 0;
    localparam int FU_JUMP = 1;
    localparam int FU_MEM  = 2;
    localparam int FU_MUL  = 3;
    localparam int FU_DIV  = 4;
    function automatic int clog2_min1(input int n);
        return n > 1 ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/regfile_wr_arb.sv
// regfile_wr_arb: per-register lowest-index-wins select over all FU write requests (r0 never hit)
module regfile_wr_arb #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32,
    parameter int NFU   = 5,
    parameter int AW    = 5,
    parameter int TW    = 3
) (
    input  logic [NFU-1:0]                 wr_en,
    input  logic [NFU*AW-1:0]              wr_addr,
    input  logic [NFU*XLEN-1:0]            wr_data,
    output logic [NREGS-1:0]               hit,
    output logic [NREGS-1:0][TW-1:0]       win_tag,
    output logic [NREGS-1:0][XLEN-1:0]     win_data
);
    always_comb begin
        hit = '0;
        win_tag = '0;
        win_data = '0;
        for (int r = 1; r < NREGS; r++)
            for (int k = NFU - 1; k >= 0; k--)
                if (wr_en[k] && wr_addr[k*AW +: AW] == AW'(r)) begin
                    hit[r] = 1'b1;
                    win_tag[r] = TW'(k);
                    win_data[r] = wr_data[k*XLEN +: XLEN];
                end
    end
endmodule

// File: rtl/regfile_mfu.sv
// regfile_mfu: NFU-port register file with busy/tag tracking; REGFILE_BYPASS_EN forwards same-cycle writes to reads
module regfile_mfu
    import regfile_pkg::*;
#(
    parameter int XLEN  = DEF_XLEN,
    parameter int NREGS = DEF_NREGS,
    parameter int NFU   = DEF_NFU,
    localparam int AW   = clog2_min1(NREGS),
    localparam int TW   = clog2_min1(NFU)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NFU*AW-1:0]     rd_addr_a,
    input  logic [NFU*AW-1:0]     rd_addr_b,
    output logic [NFU*XLEN-1:0]   rd_data_a,
    output logic [NFU*XLEN-1:0]   rd_data_b,
    input  logic [NFU-1:0]        wr_en,
    input  logic [NFU*AW-1:0]     wr_addr,
    input  logic [NFU*XLEN-1:0]   wr_data,
    input  logic                  iss_valid,
    input  logic [AW-1:0]         iss_rd,
    input  logic [TW-1:0]         iss_fu,
    output logic [NREGS-1:0]      busy_vec,
    output logic [NREGS*TW-1:0]   tag_vec,
    input  logic [AW-1:0]         dbg_addr,
    output logic [XLEN-1:0]       dbg_data
);
    logic [NREGS-1:0][XLEN-1:0] data_q, data_d, win_data, view;
    logic [NREGS-1:0][TW-1:0]   tag_q, tag_d, win_tag;
    logic [NREGS-1:0]           busy_q, busy_d, hit;

    regfile_wr_arb #(.XLEN(XLEN), .NREGS(NREGS), .NFU(NFU), .AW(AW), .TW(TW)) u_arb (
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .hit      (hit),
        .win_tag  (win_tag),
        .win_data (win_data)
    );

    // Issue is applied after writeback so a same-cycle reservation keeps the register busy
    always_comb begin
        data_d = data_q;
        busy_d = busy_q;
        tag_d = tag_q;
        for (int r = 1; r < NREGS; r++) begin
            if (hit[r]) begin
                data_d[r] = win_data[r];
                if (busy_q[r] && tag_q[r] == win_tag[r]) busy_d[r] = 1'b0;
            end
            if (iss_valid && iss_rd == AW'(r)) begin
                busy_d[r] = 1'b1;
                tag_d[r] = iss_fu;
            end
        end
        data_d[0] = '0;
        busy_d[0] = 1'b0;
        tag_d[0] = '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            data_q <= '0;
            busy_q <= '0;
            tag_q <= '0;
        end else begin
            data_q <= data_d;
            busy_q <= busy_d;
            tag_q <= tag_d;
        end
    end

    always_comb begin
        for (int r = 0; r < NREGS; r++) begin
`ifdef REGFILE_BYPASS_EN
            view[r] = hit[r] ? win_data[r] : data_q[r];
`else
            view[r] = data_q[r];
`endif
        end
        view[0] = '0;
    end

    for (genvar k = 0; k < NFU; k++) begin : g_rd
        assign rd_data_a[k*XLEN +: XLEN] = view[rd_addr_a[k*AW +: AW]];
        assign rd_data_b[k*XLEN +: XLEN] = view[rd_addr_b[k*AW +: AW]];
    end

    assign dbg_data = view[dbg_addr];
    assign busy_vec = busy_q;
    assign tag_vec = tag_q;
endmodule
